// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - shared SDR datapath constants and CIC width helpers
//
// Purpose: defaults shared by the TX CIC interpolator and the RX CIC decimator,
// so that both ends always use the same stage count and rate ratio.
// Contents:
//   CIC_STAGES      default CIC order N
//   CIC_LOG2_RATIO  default log2 of the rate-change ratio R
//   clog2()         ceiling log2 of a positive integer
//   cic_acc_width() internal comb/integrator width for a given configuration
package sdr_pkg;

    localparam int CIC_STAGES     = 3;
    localparam int CIC_LOG2_RATIO = 14;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Interpolator register growth is R^(N-1) times the input span; one extra
    // bit keeps the sign of a full-scale sample unambiguous in the comb chain.
    function automatic int cic_acc_width(input int width_in, input int stages,
                                         input int log2_ratio);
        return width_in + (stages - 1) * log2_ratio + 1;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// rtl/cic_integrator.sv - single wrapping CIC integrator stage
//
// Purpose: acc <= acc + din on every clk, modulo 2^ACC_W. Wrap-around is
// intentional: the comb/integrator pair only recovers the right result when
// every stage uses two's-complement modular arithmetic.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset, clears the accumulator
//   din    value added on each clock
//   acc    accumulator state
module cic_integrator
    import sdr_pkg::*;
#(
    parameter int ACC_W = cic_acc_width(8, CIC_STAGES, CIC_LOG2_RATIO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] din,
    output logic [ACC_W-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/cic_interpolator.sv
// rtl/cic_interpolator.sv - N-stage CIC interpolator by 2^LOG2_RATIO, unity DC gain
//
// Purpose: takes low-rate signed samples over a valid/ready handshake, runs them
// through comb -> zero-stuff -> integrators and emits one full-rate sample per clk.
// The output is the last integrator scaled by 2^-((N-1)*LOG2_RATIO) (floor).
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   d_in         signed low-rate sample
//   d_in_valid   d_in holds a sample
//   d_in_ready   one-cycle strobe every R clocks; transfer on valid && ready
//   d_out        signed full-rate sample
//   d_out_valid  sticky, set when the first accepted sample reaches d_out
//   underrun     sticky, a ready strobe found d_in_valid low
module cic_interpolator
    import sdr_pkg::*;
#(
    parameter int WIDTH_IN   = 8,
    parameter int WIDTH_OUT  = 8,
    parameter int STAGES     = CIC_STAGES,
    parameter int LOG2_RATIO = CIC_LOG2_RATIO
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH_IN-1:0]  d_in,
    input  logic                 d_in_valid,
    output logic                 d_in_ready,
    output logic [WIDTH_OUT-1:0] d_out,
    output logic                 d_out_valid,
    output logic                 underrun
);

    localparam int ACC_W   = cic_acc_width(WIDTH_IN, STAGES, LOG2_RATIO);
    localparam int OUT_MSB = WIDTH_IN + (STAGES - 1) * LOG2_RATIO - 1;
    localparam int OUT_LSB = OUT_MSB - WIDTH_OUT + 1;

    // Rate phase: the low-rate strobe is phase 0, which is also the reset
    // value, so the first strobe lands in the first cycle after release.
    logic [LOG2_RATIO-1:0] phase;
    logic                  strobe;
    logic                  accept;

    assign strobe     = (phase == '0);
    assign accept     = strobe && d_in_valid;
    assign d_in_ready = strobe && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else begin
            phase <= phase + LOG2_RATIO'(1);
        end
    end

    // Held sample: on an underrun the last good sample is repeated rather than
    // zero-filled, which keeps a DC level steady through a missed transfer.
    logic [WIDTH_IN-1:0] held;
    logic [WIDTH_IN-1:0] feed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (accept) begin
            held <= d_in;
        end
    end

    assign feed = d_in_valid ? d_in : held;

    // Comb chain: combinational through all stages, delays advance on strobes.
    logic [ACC_W-1:0] comb_x   [STAGES+1];
    logic [ACC_W-1:0] comb_dly [STAGES];

    assign comb_x[0] = ACC_W'($signed(feed));

    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        assign comb_x[k+1] = comb_x[k] - comb_dly[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                comb_dly[k] <= '0;
            end
        end else if (strobe) begin
            for (int k = 0; k < STAGES; k++) begin
                comb_dly[k] <= comb_x[k];
            end
        end
    end

    // Zero-stuff: the comb result appears for one clk, zeros fill the rest.
    logic [ACC_W-1:0] zstuff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zstuff <= '0;
        end else begin
            zstuff <= strobe ? comb_x[STAGES] : '0;
        end
    end

    // Integrator cascade, each stage fed by the registered previous stage.
    logic [ACC_W-1:0] integ    [STAGES];
    logic [ACC_W-1:0] integ_in [STAGES];

    assign integ_in[0] = zstuff;

    for (genvar k = 0; k < STAGES; k++) begin : g_integ
        if (k > 0) begin : g_link
            assign integ_in[k] = integ[k-1];
        end
        cic_integrator #(
            .ACC_W (ACC_W)
        ) u_integ (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (integ_in[k]),
            .acc   (integ[k])
        );
    end

    // accept_pipe[k] marks that an accepted sample is k+1 clocks past its
    // strobe; d_out first carries it one register after the last integrator.
    logic [STAGES:0] accept_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out       <= '0;
            d_out_valid <= 1'b0;
            underrun    <= 1'b0;
            accept_pipe <= '0;
        end else begin
            d_out       <= integ[STAGES-1][OUT_MSB:OUT_LSB];
            accept_pipe <= {accept_pipe[STAGES-1:0], accept};
            if (accept_pipe[STAGES]) begin
                d_out_valid <= 1'b1;
            end
            if (strobe && !d_in_valid) begin
                underrun <= 1'b1;
            end
        end
    end

    // Bits of the last integrator below the output LSB (dropped by the floor
    // scaling) and the guard MSB are deliberately not brought out.
    logic unused_integ_bits;

    if (OUT_LSB > 0) begin : g_unused_lsb
        assign unused_integ_bits = ^{integ[STAGES-1][ACC_W-1],
                                     integ[STAGES-1][OUT_LSB-1:0]};
    end else begin : g_unused_msb
        assign unused_integ_bits = integ[STAGES-1][ACC_W-1];
    end

endmodule
